// File: rtl/rom_port_arbiter_if.sv
// Bus bundle for rom_port_arbiter: fetch port, debug burst port and ROM port.
// oob_err exists only when ROM_PORT_ARB_BOUNDS_EN is defined.
interface rom_port_arbiter_if #(
  parameter int unsigned LEN_W = 8
);
  logic             if_req;
  logic [30:0]      if_addr;
  logic             if_gnt;
  logic             if_stall;
  logic             if_valid;
  logic [31:0]      if_data;

  logic             dbg_start;
  logic [28:0]      dbg_base;
  logic [LEN_W-1:0] dbg_len;
  logic             dbg_ready;
  logic             dbg_busy;
  logic             dbg_valid;
  logic [31:0]      dbg_data;
  logic             dbg_done;

  logic [30:0]      rom_addr;
  logic [31:0]      rom_data;

`ifdef ROM_PORT_ARB_BOUNDS_EN
  logic             oob_err;
`endif

  modport slave (
`ifdef ROM_PORT_ARB_BOUNDS_EN
    output oob_err,
`endif
    input  if_req, if_addr,
    output if_gnt, if_stall, if_valid, if_data,
    input  dbg_start, dbg_base, dbg_len, dbg_ready,
    output dbg_busy, dbg_valid, dbg_data, dbg_done,
    output rom_addr,
    input  rom_data
  );

  modport master (
`ifdef ROM_PORT_ARB_BOUNDS_EN
    input  oob_err,
`endif
    output if_req, if_addr,
    input  if_gnt, if_stall, if_valid, if_data,
    output dbg_start, dbg_base, dbg_len, dbg_ready,
    input  dbg_busy, dbg_valid, dbg_data, dbg_done,
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one combinational ROM read port between instruction fetch (priority) and a
// debug burst reader with starvation guard. Optional bounds check: ROM_PORT_ARB_BOUNDS_EN.
module rom_port_arbiter #(
  parameter int unsigned ROM_WORDS    = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LEN_W        = 8
) (
  input logic               clk,
  input logic               reset,
  rom_port_arbiter_if.slave bus
);

  if (ROM_WORDS < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
    $error("rom_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {s_idle, s_burst, s_flush, s_done} state_t;

  localparam logic [7:0]       STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

  state_t           state, state_nxt;
  logic [28:0]      ptr, ptr_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [7:0]       starve, starve_nxt;
  logic             dbg_req_int;
  logic             dbg_gnt;
  logic             if_gnt;
  logic [31:0]      rd_data;

  assign dbg_req_int  = (state == s_burst) && bus.dbg_ready;
  assign dbg_gnt      = dbg_req_int && (!bus.if_req || (starve == STARVE_MAX));
  assign if_gnt       = bus.if_req && !dbg_gnt;

  assign bus.if_gnt   = if_gnt;
  assign bus.if_stall = bus.if_req && !if_gnt;
  assign bus.rom_addr = dbg_gnt ? {ptr, 2'b00} : bus.if_addr;
  assign bus.dbg_busy = (state == s_burst) || (state == s_flush);
  assign bus.dbg_done = (state == s_done);

`ifdef ROM_PORT_ARB_BOUNDS_EN
  logic [28:0] gnt_idx;
  logic        oob;

  assign gnt_idx = dbg_gnt ? ptr : bus.if_addr[30:2];
  assign oob     = {3'b000, gnt_idx} >= ROM_WORDS;
  assign rd_data = oob ? '0 : bus.rom_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.oob_err <= 1'b0;
    end else begin
      bus.oob_err <= (dbg_gnt || if_gnt) && oob;
    end
  end
`else
  assign rd_data = bus.rom_data;
`endif

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    case (state)
      s_idle: begin
        if (bus.dbg_start) begin
          if (bus.dbg_len != '0) begin
            ptr_nxt       = bus.dbg_base;
            remaining_nxt = bus.dbg_len;
            state_nxt     = s_burst;
          end else begin
            state_nxt = s_done;
          end
        end
      end
      s_burst: begin
        if (dbg_gnt) begin
          ptr_nxt       = ptr + 29'd1;
          remaining_nxt = remaining - LEN_ONE;
          if (remaining == LEN_ONE) state_nxt = s_flush;
        end
      end
      s_flush: state_nxt = s_done;
      s_done:  state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase
  end

  // Counter only runs while debug is actively asking and losing; saturates at the limit.
  always_comb begin
    starve_nxt = starve;
    if (!dbg_req_int || dbg_gnt) begin
      starve_nxt = '0;
    end else if (starve != STARVE_MAX) begin
      starve_nxt = starve + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= s_idle;
      ptr           <= '0;
      remaining     <= '0;
      starve        <= '0;
      bus.if_valid  <= 1'b0;
      bus.if_data   <= '0;
      bus.dbg_valid <= 1'b0;
      bus.dbg_data  <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      remaining     <= remaining_nxt;
      starve        <= starve_nxt;
      bus.if_valid  <= if_gnt;
      bus.dbg_valid <= dbg_gnt;
      if (if_gnt)  bus.if_data  <= rd_data;
      if (dbg_gnt) bus.dbg_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter; ROM word at index i is 32'hDEAD0000+i.
module tb_rom_port_arbiter;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_errors;

  rom_port_arbiter_if #(.LEN_W(8)) bus();

  rom_port_arbiter #(
    .ROM_WORDS   (32),
    .STARVE_LIMIT(4),
    .LEN_W       (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.rom_data = 32'hDEAD_0000 + (32'(bus.rom_addr) >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [28:0] base, input logic [7:0] len);
    bus.dbg_base  = base;
    bus.dbg_len   = len;
    bus.dbg_start = 1'b1;
    tick();
    bus.dbg_start = 1'b0;
  endtask

  logic        bp_rdy  [1:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] bp_addr [1:6] = '{32'h50, 32'h0, 32'h0, 32'h54, 32'h0, 32'h0};
  logic        bp_val  [1:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        bp_done [1:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] burst_words [0:2] = '{32'hDEAD0005, 32'hDEAD0006, 32'hDEAD0007};

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dbg_start = 1'b0;
    bus.dbg_base  = '0;
    bus.dbg_len   = '0;
    bus.dbg_ready = 1'b0;
    #3;
    check("rst_if_valid",  bus.if_valid,  0);
    check("rst_if_data",   bus.if_data,   0);
    check("rst_dbg_valid", bus.dbg_valid, 0);
    check("rst_dbg_data",  bus.dbg_data,  0);
    check("rst_dbg_busy",  bus.dbg_busy,  0);
    check("rst_dbg_done",  bus.dbg_done,  0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Fetch only
    bus.if_req  = 1'b1;
    bus.if_addr = 31'h14;
    #1;
    check("fetch_gnt",   bus.if_gnt,   1);
    check("fetch_stall", bus.if_stall, 0);
    check("fetch_addr",  bus.rom_addr, 32'h14);
    tick();
    bus.if_req = 1'b0;
    #1;
    check("fetch_valid", bus.if_valid, 1);
    check("fetch_data",  bus.if_data,  32'hDEAD0005);
    tick();
    check("fetch_valid_drop", bus.if_valid, 0);

    // Idle burst of 3 words
    bus.dbg_ready = 1'b1;
    start_burst(29'd5, 8'd3);
    #1;
    check("burst_busy", bus.dbg_busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("burst_valid", bus.dbg_valid, 1);
      check("burst_data",  bus.dbg_data,  burst_words[i]);
    end
    check("burst_flush_busy", bus.dbg_busy, 1);
    tick();
    check("burst_done",       bus.dbg_done,  1);
    check("burst_done_busy",  bus.dbg_busy,  0);
    check("burst_done_valid", bus.dbg_valid, 0);
    tick();
    check("burst_done_drop", bus.dbg_done, 0);

    // Starvation: fetch held high, debug wins on cycles 5 and 10
    bus.if_req  = 1'b1;
    bus.if_addr = 31'h40;
    start_burst(29'd8, 8'd2);
    for (int k = 1; k <= 12; k++) begin
      #1;
      check("starve_stall",    bus.if_stall,  (k == 5 || k == 10) ? 32'd1 : 32'd0);
      check("starve_dbgvalid", bus.dbg_valid, (k == 6 || k == 11) ? 32'd1 : 32'd0);
      check("starve_ifvalid",  bus.if_valid,  (k == 6 || k == 11) ? 32'd0 : 32'd1);
      check("starve_done",     bus.dbg_done,  (k == 12) ? 32'd1 : 32'd0);
      if (k == 6)  check("starve_data0", bus.dbg_data, 32'hDEAD0008);
      if (k == 11) check("starve_data1", bus.dbg_data, 32'hDEAD0009);
      tick();
    end
    bus.if_req  = 1'b0;
    bus.if_addr = '0;

    // Backpressure: ready 1,0,0,1 during a 2-word burst
    start_burst(29'd20, 8'd2);
    for (int k = 1; k <= 6; k++) begin
      bus.dbg_ready = bp_rdy[k];
      #1;
      check("bp_addr",  bus.rom_addr,  bp_addr[k]);
      check("bp_valid", bus.dbg_valid, 32'(bp_val[k]));
      check("bp_done",  bus.dbg_done,  32'(bp_done[k]));
      if (k == 2) check("bp_data0", bus.dbg_data, 32'hDEAD0014);
      if (k == 5) check("bp_data1", bus.dbg_data, 32'hDEAD0015);
      tick();
    end
    bus.dbg_ready = 1'b1;

    // Zero length goes straight to DONE; start during DONE is ignored
    start_burst(29'd3, 8'd0);
    bus.dbg_start = 1'b1;
    bus.dbg_len   = 8'd1;
    #1;
    check("len0_done", bus.dbg_done, 1);
    check("len0_busy", bus.dbg_busy, 0);
    tick();
    bus.dbg_start = 1'b0;
    #1;
    check("len0_done_drop",   bus.dbg_done, 0);
    check("done_start_ignored", bus.dbg_busy, 0);
    tick();
    check("done_start_novalid", bus.dbg_valid, 0);

    // Reset mid-burst
    start_burst(29'd0, 8'd4);
    tick();
    check("mid_valid_pre", bus.dbg_valid, 1);
    check("mid_busy_pre",  bus.dbg_busy,  1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid",   bus.dbg_valid, 0);
    check("mid_rst_busy",    bus.dbg_busy,  0);
    check("mid_rst_dbgdata", bus.dbg_data,  0);
    check("mid_rst_ifdata",  bus.if_data,   0);
    check("mid_rst_done",    bus.dbg_done,  0);
    #2;
    reset = 1'b1;
    tick();
    check("post_rst_busy", bus.dbg_busy, 0);
    check("post_rst_done", bus.dbg_done, 0);
    start_burst(29'd2, 8'd1);
    #1;
    check("post_rst_burst_busy", bus.dbg_busy, 1);
    tick();
    check("post_rst_valid", bus.dbg_valid, 1);
    check("post_rst_data",  bus.dbg_data,  32'hDEAD0002);
    tick();
    check("post_rst_done2", bus.dbg_done, 1);
    tick();
    check("post_rst_idle", bus.dbg_done, 0);

`ifdef ROM_PORT_ARB_BOUNDS_EN
    // Burst running past the end of a 32-word ROM
    start_burst(29'd30, 8'd4);
    check("oob_idle", bus.oob_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("oob_valid", bus.dbg_valid, 1);
      check("oob_data",  bus.dbg_data,  (i == 0) ? 32'hDEAD001E : (i == 1) ? 32'hDEAD001F : 32'h0);
      check("oob_err",   bus.oob_err,   (i >= 2) ? 32'd1 : 32'd0);
    end
    tick();
    check("oob_done",     bus.dbg_done, 1);
    check("oob_err_drop", bus.oob_err,  0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
